// File: rtl/grid_bram_arbiter.sv
// grid_bram_arbiter
// Shares the single port of the fluid-grid BRAM between the display read
// stream and the D2Q9 simulation stepper. Display wins during active video
// (with a starvation escape for the simulator); the simulator wins during
// blanking. Read data returns to its originator through a tagged pipeline
// with fixed latency READ_LATENCY+1 cycles after the grant cycle.
//
// READ_LATENCY counts the arbiter's own address register plus the BRAM's
// read register(s): bram_dout_in is expected to hold the word for the issued
// address during the cycle in which the tag reaches the last pipeline stage.

module grid_bram_arbiter #(
  parameter  int BRAM_DEPTH   = 31570,
  parameter  int DATA_WIDTH   = 72,
  parameter  int READ_LATENCY = 2,
  parameter  int STARVE_LIMIT = 15,
  localparam int ADDR_W       = $clog2(BRAM_DEPTH)
) (
  input  logic                  pixel_clk_in,
  input  logic                  rst_in,
  input  logic                  blank_in,
  input  logic                  disp_req_in,
  input  logic [ADDR_W-1:0]     disp_addr_in,
  output logic                  disp_gnt_out,
  output logic                  disp_valid_out,
  output logic [DATA_WIDTH-1:0] disp_data_out,
  input  logic                  sim_req_in,
  input  logic                  sim_we_in,
  input  logic [ADDR_W-1:0]     sim_addr_in,
  input  logic [DATA_WIDTH-1:0] sim_wdata_in,
  output logic                  sim_gnt_out,
  output logic                  sim_valid_out,
  output logic [DATA_WIDTH-1:0] sim_data_out,
  output logic [ADDR_W-1:0]     bram_addr_out,
  output logic                  bram_we_out,
  output logic [DATA_WIDTH-1:0] bram_din_out,
  input  logic [DATA_WIDTH-1:0] bram_dout_in,
  output logic                  oob_err_out
);

  localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W:0]   DEPTH_EXT  = (ADDR_W + 1)'(BRAM_DEPTH);

  typedef enum logic {
    DISP_PRI,
    SIM_PRI
  } state_e;

  // Read-return tag: who issued the read and whether it was out of range.
  typedef struct packed {
    logic disp;
    logic sim;
    logic oob;
  } tag_t;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        starve_q, starve_d;
  logic [ADDR_W-1:0]       bram_addr_q;
  logic                    bram_we_q;
  logic [DATA_WIDTH-1:0]   bram_din_q;
  logic                    oob_q;

  tag_t                    tag_q [READ_LATENCY];
  tag_t                    tag_d;
  logic                    disp_valid_q, sim_valid_q;
  logic [DATA_WIDTH-1:0]   disp_data_q, sim_data_q;

  logic                    disp_gnt, sim_gnt, any_gnt;
  logic                    sim_forced;
  logic [ADDR_W-1:0]       req_addr;
  logic                    req_oob;
  tag_t                    tag_last;

  assign sim_forced = sim_req_in & (starve_q == STARVE_MAX);

  // Combinational grant: priority by state, starvation escape in DISP_PRI.
  // Grants are held low during reset so every output reads 0 while rst_in=0.
  always_comb begin
    disp_gnt = 1'b0;
    sim_gnt  = 1'b0;
    if (rst_in) begin
      if (state_q == SIM_PRI) begin
        sim_gnt  = sim_req_in;
        disp_gnt = disp_req_in & ~sim_req_in;
      end else begin
        disp_gnt = disp_req_in & ~sim_forced;
        sim_gnt  = sim_req_in & ~disp_gnt;
      end
    end
  end

  assign any_gnt = disp_gnt | sim_gnt;

  // Winner's address and range check feeding the issue registers.
  always_comb begin
    req_addr = sim_gnt ? sim_addr_in : disp_addr_in;
    req_oob  = ({1'b0, req_addr} >= DEPTH_EXT);
  end

  // Next state / starvation counter: counter only runs while display has
  // priority and the simulator is waiting; any sim grant or idle sim clears it.
  always_comb begin
    state_d  = blank_in ? SIM_PRI : DISP_PRI;
    starve_d = '0;
    if ((state_q == DISP_PRI) && sim_req_in && !sim_gnt) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
    end
  end

  // Tag for the access being granted this cycle; writes carry no return.
  always_comb begin
    tag_d      = '0;
    tag_d.disp = disp_gnt;
    tag_d.sim  = sim_gnt & ~sim_we_in;
    tag_d.oob  = any_gnt & req_oob;
  end

  // FSM, starvation counter and registered BRAM issue port.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= DISP_PRI;
      starve_q    <= '0;
      bram_addr_q <= '0;
      bram_we_q   <= 1'b0;
      bram_din_q  <= '0;
      oob_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      oob_q     <= any_gnt & req_oob;
      bram_we_q <= sim_gnt & sim_we_in & ~req_oob;
      if (any_gnt) begin
        bram_addr_q <= req_oob ? '0 : req_addr;
        bram_din_q  <= sim_gnt ? sim_wdata_in : '0;
      end
    end
  end

  assign tag_last = tag_q[READ_LATENCY-1];

  // Tag shift pipeline and registered read return; reset drops in-flight reads.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < unsigned'(READ_LATENCY); i++) begin
        tag_q[i] <= '0;
      end
      disp_valid_q <= 1'b0;
      sim_valid_q  <= 1'b0;
      disp_data_q  <= '0;
      sim_data_q   <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int unsigned i = 1; i < unsigned'(READ_LATENCY); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      disp_valid_q <= tag_last.disp;
      sim_valid_q  <= tag_last.sim;
      if (tag_last.disp) begin
        disp_data_q <= tag_last.oob ? '0 : bram_dout_in;
      end
      if (tag_last.sim) begin
        sim_data_q <= tag_last.oob ? '0 : bram_dout_in;
      end
    end
  end

  assign disp_gnt_out   = disp_gnt;
  assign sim_gnt_out    = sim_gnt;
  assign disp_valid_out = disp_valid_q;
  assign disp_data_out  = disp_data_q;
  assign sim_valid_out  = sim_valid_q;
  assign sim_data_out   = sim_data_q;
  assign bram_addr_out  = bram_addr_q;
  assign bram_we_out    = bram_we_q;
  assign bram_din_out   = bram_din_q;
  assign oob_err_out    = oob_q;

endmodule
